// File: rtl/char_pkg.sv
// Shared character codes, rotator state encoding and word/offset helpers.
package char_pkg;

  localparam logic [1:0] CH_D = 2'b00;
  localparam logic [1:0] CH_E = 2'b01;
  localparam logic [1:0] CH_1 = 2'b10;
  localparam logic [1:0] CH_0 = 2'b11;

  localparam logic [7:0] RESET_WORD = {CH_D, CH_E, CH_1, CH_0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Output slot i takes pattern slot (i - off) mod 4: a left rotate by 2*off bits.
  function automatic logic [7:0] rotate_word(input logic [7:0] w, input logic [1:0] off);
    logic [7:0] r;
    case (off)
      2'd0:    r = w;
      2'd1:    r = {w[5:0], w[7:6]};
      2'd2:    r = {w[3:0], w[7:4]};
      default: r = {w[1:0], w[7:2]};
    endcase
    return r;
  endfunction

  function automatic logic [1:0] next_offset(input logic [1:0] off, input logic dir);
    return dir ? (off - 2'd1) : (off + 2'd1);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: tick_o is high for the cycle the count sits at TICK_DIV-1.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // tick is registered alongside the count so it tracks cnt_q == LAST exactly
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    if (clr_i) cnt_d = '0;
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/char_rotator.sv
// Scrolls a 4-character word across four display positions at the prescaled rate.
// Optional HOLD-state single-step button enabled by CHAR_ROTATOR_STEP_EN.
module char_rotator
  import char_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic [7:0] chars_in,
  input  logic       load,
  input  logic       run,
  input  logic       dir,
  input  logic       step,
  output logic [7:0] pos_out,
  output logic [1:0] offset,
  output logic       tick
);

  state_e     state_q, state_d;
  logic [7:0] pattern_q, pattern_d;
  logic [1:0] offset_q, offset_d;
  logic [7:0] pos_out_q, pos_out_d;
  logic       tick_clr_c;
  logic       step_press_c;

  tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_gen (
    .clk    (CLOCK_50),
    .rst_n  (KEY0),
    .clr_i  (tick_clr_c),
    .tick_o (tick)
  );

`ifdef CHAR_ROTATOR_STEP_EN
  logic [1:0] step_sync_q;
  logic       step_prev_q;

  // Button idles high; a press is a synchronised high-to-low transition.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      step_sync_q <= 2'b11;
      step_prev_q <= 1'b1;
    end else begin
      step_sync_q <= {step_sync_q[0], step};
      step_prev_q <= step_sync_q[1];
    end
  end

  assign step_press_c = step_prev_q & ~step_sync_q[1];
`else
  logic step_unused;
  assign step_unused  = step;
  assign step_press_c = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    offset_d   = offset_q;
    tick_clr_c = 1'b0;
    pos_out_d  = rotate_word(pattern_q, offset_q);
    if (load) begin
      state_d    = HOLD;
      pattern_d  = chars_in;
      offset_d   = 2'd0;
      tick_clr_c = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          offset_d = 2'd0;
          if (run) state_d = RUN;
        end
        HOLD: begin
          if (run) state_d = RUN;
          if (step_press_c) offset_d = next_offset(offset_q, dir);
        end
        RUN: begin
          // run is checked before tick, so a falling run swallows a coincident tick
          if (!run)      state_d  = HOLD;
          else if (tick) offset_d = next_offset(offset_q, dir);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q   <= IDLE;
      pattern_q <= RESET_WORD;
      offset_q  <= 2'd0;
      pos_out_q <= RESET_WORD;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      offset_q  <= offset_d;
      pos_out_q <= pos_out_d;
    end
  end

  assign pos_out = pos_out_q;
  assign offset  = offset_q;

endmodule
